// File: rtl/pe_pkg.sv
// Shared constants and saturation-limit helpers for the weight-stationary PE.
package pe_pkg;

   localparam int unsigned PE_DATA_W = 8;
   localparam int unsigned PE_ACC_W  = 32;

   // Largest value representable in acc_w bits (signed or unsigned), zero-extended to 64 bits.
   function automatic logic [63:0] sat_max(input int unsigned acc_w, input bit signed_mode);
      logic [63:0] one;
      one = 64'd1;
      if (signed_mode)
         sat_max = (one << (acc_w - 1)) - one;
      else if (acc_w >= 64)
         sat_max = '1;
      else
         sat_max = (one << acc_w) - one;
   endfunction

   // Smallest value representable in acc_w bits, as an acc_w-bit pattern zero-extended to 64 bits.
   function automatic logic [63:0] sat_min(input int unsigned acc_w, input bit signed_mode);
      logic [63:0] one;
      one = 64'd1;
      if (signed_mode)
         sat_min = one << (acc_w - 1);
      else
         sat_min = '0;
   endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational multiply-accumulate with overflow detection and optional clamping.
module pe_mac_sat
   import pe_pkg::*;
#(
   parameter int unsigned DATA_W      = PE_DATA_W,
   parameter int unsigned ACC_W       = PE_ACC_W,
   parameter bit          SIGNED_MODE = 1'b1,
   parameter bit          SATURATE    = 1'b1
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] w,
   input  logic [ACC_W-1:0]  acc_in,
   output logic [ACC_W-1:0]  sum_c,
   output logic              ovf_c
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned EXT_W  = ACC_W + 1;

   localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W, SIGNED_MODE));
   localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W, SIGNED_MODE));

   logic [PROD_W-1:0] a_x;
   logic [PROD_W-1:0] w_x;
   logic [PROD_W-1:0] prod;
   logic [EXT_W-1:0]  prod_x;
   logic [EXT_W-1:0]  acc_x;
   logic [EXT_W-1:0]  sum_x;

   // Extend operands, form the exact product and the one-bit-wider sum, then classify it.
   always_comb begin
      a_x    = SIGNED_MODE ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
      w_x    = SIGNED_MODE ? {{DATA_W{w[DATA_W-1]}}, w} : {{DATA_W{1'b0}}, w};
      prod   = a_x * w_x;
      prod_x = {{(EXT_W - PROD_W){SIGNED_MODE ? prod[PROD_W-1] : 1'b0}}, prod};
      acc_x  = {SIGNED_MODE ? acc_in[ACC_W-1] : 1'b0, acc_in};
      sum_x  = acc_x + prod_x;

      // Signed: top two bits disagree. Unsigned: carry out (product is never negative).
      if (SIGNED_MODE)
         ovf_c = sum_x[EXT_W-1] ^ sum_x[ACC_W-1];
      else
         ovf_c = sum_x[EXT_W-1];

      sum_c = sum_x[ACC_W-1:0];
      if (ovf_c && SATURATE) begin
         if (SIGNED_MODE && sum_x[EXT_W-1])
            sum_c = ACC_MIN;
         else
            sum_c = ACC_MAX;
      end
   end

endmodule

// File: rtl/pe_ws_db.sv
// Weight-stationary systolic PE with double-buffered (shadow/active) weights.
module pe_ws_db
   import pe_pkg::*;
#(
   parameter int unsigned DATA_W      = PE_DATA_W,
   parameter int unsigned ACC_W       = PE_ACC_W,
   parameter bit          SIGNED_MODE = 1'b1,
   parameter bit          SATURATE    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] a_in,
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [DATA_W-1:0] w_in,
   input  logic              w_load,
   input  logic              w_swap,
   input  logic              clr_ovf,
   output logic              valid_out,
   output logic [DATA_W-1:0] a_out,
   output logic [ACC_W-1:0]  acc_out,
   output logic [DATA_W-1:0] w_out,
   output logic              w_swap_out,
   output logic              ovf
);

   logic [DATA_W-1:0] w_active;
   logic [ACC_W-1:0]  sum_c;
   logic              ovf_c;

   pe_mac_sat #(
      .DATA_W      (DATA_W),
      .ACC_W       (ACC_W),
      .SIGNED_MODE (SIGNED_MODE),
      .SATURATE    (SATURATE)
   ) u_mac (
      .a      (a_in),
      .w      (w_active),
      .acc_in (acc_in),
      .sum_c  (sum_c),
      .ovf_c  (ovf_c)
   );

   // Datapath pipeline: capture MAC result and pass activation through on valid cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_out <= 1'b0;
         a_out     <= '0;
         acc_out   <= '0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            a_out   <= a_in;
            acc_out <= sum_c;
         end
      end
   end

   // Weight double buffer; swap reads the pre-load shadow, so load+swap commits the old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_out      <= '0;
         w_active   <= '0;
         w_swap_out <= 1'b0;
      end else begin
         w_swap_out <= w_swap;
         if (w_load)
            w_out <= w_in;
         if (w_swap)
            w_active <= w_out;
      end
   end

   // Sticky overflow flag; a new overflow wins over a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ovf <= 1'b0;
      else if (valid_in && ovf_c)
         ovf <= 1'b1;
      else if (clr_ovf)
         ovf <= 1'b0;
   end

endmodule

// File: tb/tb_pe_ws_db.sv
// Directed bench for pe_ws_db: defaults, 17-bit saturate/wrap variants and a 4-row weight chain.
module tb_pe_ws_db;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- default-parameter PE ----------------
   logic        d_valid, d_wl, d_ws, d_clr;
   logic [7:0]  d_a, d_w;
   logic [31:0] d_acc;
   logic        d_vo, d_wso, d_ovf;
   logic [7:0]  d_ao, d_wo;
   logic [31:0] d_acco;

   pe_ws_db u_def (
      .clk (clk), .reset (reset), .valid_in (d_valid), .a_in (d_a), .acc_in (d_acc),
      .w_in (d_w), .w_load (d_wl), .w_swap (d_ws), .clr_ovf (d_clr),
      .valid_out (d_vo), .a_out (d_ao), .acc_out (d_acco), .w_out (d_wo),
      .w_swap_out (d_wso), .ovf (d_ovf)
   );

   // ---------------- 17-bit saturating and wrapping PEs (shared stimulus) ----------------
   logic        s_valid, s_wl, s_ws, s_clr;
   logic [7:0]  s_a, s_w;
   logic [16:0] s_acc;
   logic        sat_vo, sat_wso, sat_ovf, wr_vo, wr_wso, wr_ovf;
   logic [7:0]  sat_ao, sat_wo, wr_ao, wr_wo;
   logic [16:0] sat_acco, wr_acco;

   pe_ws_db #(.DATA_W (8), .ACC_W (17), .SIGNED_MODE (1'b1), .SATURATE (1'b1)) u_sat (
      .clk (clk), .reset (reset), .valid_in (s_valid), .a_in (s_a), .acc_in (s_acc),
      .w_in (s_w), .w_load (s_wl), .w_swap (s_ws), .clr_ovf (s_clr),
      .valid_out (sat_vo), .a_out (sat_ao), .acc_out (sat_acco), .w_out (sat_wo),
      .w_swap_out (sat_wso), .ovf (sat_ovf)
   );

   pe_ws_db #(.DATA_W (8), .ACC_W (17), .SIGNED_MODE (1'b1), .SATURATE (1'b0)) u_wrap (
      .clk (clk), .reset (reset), .valid_in (s_valid), .a_in (s_a), .acc_in (s_acc),
      .w_in (s_w), .w_load (s_wl), .w_swap (s_ws), .clr_ovf (s_clr),
      .valid_out (wr_vo), .a_out (wr_ao), .acc_out (wr_acco), .w_out (wr_wo),
      .w_swap_out (wr_wso), .ovf (wr_ovf)
   );

   // ---------------- 4-row column chain ----------------
   logic [7:0]  c_w_in;
   logic        c_ws_in;
   logic [7:0]  c_w   [5];
   logic        c_s   [5];
   logic [31:0] c_acc [5];
   logic        c_vo  [4];
   logic [7:0]  c_ao  [4];
   logic        c_ovf [4];
   logic        c_wl;

   assign c_w[0]   = c_w_in;
   assign c_s[0]   = c_ws_in;
   assign c_acc[0] = 32'd0;

   for (genvar i = 0; i < 4; i++) begin : g_row
      pe_ws_db u_pe (
         .clk (clk), .reset (reset), .valid_in (1'b0), .a_in (8'd0), .acc_in (c_acc[i]),
         .w_in (c_w[i]), .w_load (c_wl), .w_swap (c_s[i]), .clr_ovf (1'b0),
         .valid_out (c_vo[i]), .a_out (c_ao[i]), .acc_out (c_acc[i+1]), .w_out (c_w[i+1]),
         .w_swap_out (c_s[i+1]), .ovf (c_ovf[i])
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      reset = 1'b1;
      d_valid = 0; d_wl = 0; d_ws = 0; d_clr = 0; d_a = '0; d_w = '0; d_acc = '0;
      s_valid = 0; s_wl = 0; s_ws = 0; s_clr = 0; s_a = '0; s_w = '0; s_acc = '0;
      c_w_in = '0; c_ws_in = 0; c_wl = 0;
      tick();
      tick();

      // Reset state
      check("rst_valid_out", 64'(d_vo), 64'd0);
      check("rst_acc_out", 64'(d_acco), 64'd0);
      check("rst_w_out", 64'(d_wo), 64'd0);
      check("rst_ovf", 64'(d_ovf), 64'd0);
      reset = 1'b0;

      // Defaults: w=3, 5*3+10 = 25
      d_w = 8'd3; d_wl = 1; tick();
      check("load_w_out", 64'(d_wo), 64'd3);
      d_wl = 0; d_ws = 1; tick();
      check("swap_out", 64'(d_wso), 64'd1);
      d_ws = 0; d_valid = 1; d_a = 8'd5; d_acc = 32'd10; tick();
      check("mac_acc", 64'(d_acco), 64'd25);
      check("mac_valid", 64'(d_vo), 64'd1);
      check("mac_a_out", 64'(d_ao), 64'd5);
      check("swap_out_drop", 64'(d_wso), 64'd0);
      d_valid = 0; d_a = 8'd99; d_acc = 32'd1234; tick();
      check("idle_valid", 64'(d_vo), 64'd0);
      check("idle_hold_acc", 64'(d_acco), 64'd25);
      check("idle_hold_a", 64'(d_ao), 64'd5);

      // Signed negatives: w=-2; -128*-2+0 = 256; 127*-2-10 = -264
      d_w = 8'hFE; d_wl = 1; tick();
      d_wl = 0; d_ws = 1; tick();
      d_ws = 0; d_valid = 1; d_a = 8'h80; d_acc = 32'd0; tick();
      check("neg_neg", 64'(d_acco), 64'd256);
      d_a = 8'd127; d_acc = 32'hFFFF_FFF6; tick();
      check("pos_neg", 64'(d_acco), 64'(32'hFFFF_FEF8));
      d_valid = 0;

      // Double buffer: active=3, shadow=7, swap with valid uses old active
      d_w = 8'd3; d_wl = 1; tick();
      d_wl = 0; d_ws = 1; tick();
      d_ws = 0; d_w = 8'd7; d_wl = 1; tick();
      d_wl = 0; d_ws = 1; d_valid = 1; d_a = 8'd2; d_acc = 32'd0; tick();
      check("db_old_active", 64'(d_acco), 64'd6);
      d_ws = 0; tick();
      check("db_new_active", 64'(d_acco), 64'd14);
      // Load+swap together: active takes old shadow 7, shadow takes 9
      d_valid = 0; d_w = 8'd9; d_wl = 1; d_ws = 1; tick();
      d_wl = 0; d_ws = 0; d_valid = 1; d_a = 8'd1; d_acc = 32'd0; tick();
      check("ldsw_active", 64'(d_acco), 64'd7);
      check("ldsw_shadow", 64'(d_wo), 64'd9);

      // 32-bit saturation at the default width: 0x7FFFFFFF + 1*1
      d_valid = 0; d_w = 8'd1; d_wl = 1; tick();
      d_wl = 0; d_ws = 1; tick();
      d_ws = 0; d_valid = 1; d_a = 8'd1; d_acc = 32'h7FFF_FFFF; tick();
      check("def_sat_acc", 64'(d_acco), 64'h7FFF_FFFF);
      check("def_sat_ovf", 64'(d_ovf), 64'd1);

      // Async reset between edges while streaming
      d_a = 8'd4; d_acc = 32'd50; tick();
      #2 reset = 1'b1;
      #1;
      check("ar_valid", 64'(d_vo), 64'd0);
      check("ar_acc", 64'(d_acco), 64'd0);
      check("ar_a", 64'(d_ao), 64'd0);
      check("ar_w_out", 64'(d_wo), 64'd0);
      check("ar_ovf", 64'(d_ovf), 64'd0);
      d_valid = 0;
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_acc", 64'(d_acco), 64'd0);
      check("post_rst_valid", 64'(d_vo), 64'd0);
      d_valid = 1; d_a = 8'd5; d_acc = 32'd10; tick();
      check("post_rst_zero_w", 64'(d_acco), 64'd10);
      d_valid = 0;

      // 17-bit: w=127; 65535 + 127*127 = 81664 -> sat 65535, wrap 81664-131072 = -49408 (0x13F00)
      s_w = 8'd127; s_wl = 1; tick();
      s_wl = 0; s_ws = 1; tick();
      s_ws = 0; s_valid = 1; s_a = 8'd127; s_acc = 17'h0FFFF; tick();
      check("sat_max", 64'(sat_acco), 64'h0FFFF);
      check("sat_ovf", 64'(sat_ovf), 64'd1);
      check("wrap_val", 64'(wr_acco), 64'h13F00);
      check("wrap_ovf", 64'(wr_ovf), 64'd1);
      s_valid = 0; tick(); tick();
      check("ovf_sticky", 64'(sat_ovf), 64'd1);
      // Overflow together with clear keeps the flag
      s_valid = 1; s_clr = 1; tick();
      check("ovf_set_beats_clr", 64'(sat_ovf), 64'd1);
      s_valid = 0; tick();
      check("ovf_cleared", 64'(sat_ovf), 64'd0);
      s_clr = 0;
      // Exactly max: 49406 + 16129 = 65535, no overflow
      s_valid = 1; s_acc = 17'd49406; tick();
      check("exact_max", 64'(sat_acco), 64'h0FFFF);
      check("exact_max_ovf", 64'(sat_ovf), 64'd0);
      // -65536 + (-128*127 = -16256) = -81792 -> sat min 0x10000, wrap 49280 (0x0C080)
      s_a = 8'h80; s_acc = 17'h10000; tick();
      check("sat_min", 64'(sat_acco), 64'h10000);
      check("wrap_neg", 64'(wr_acco), 64'h0C080);
      check("sat_min_ovf", 64'(sat_ovf), 64'd1);
      s_valid = 0;

      // Chain: four loads of 1,2,3,4 shift down the column
      c_wl = 1;
      for (int k = 1; k <= 4; k++) begin
         c_w_in = 8'(k);
         tick();
      end
      c_wl = 0;
      check("chain_row0", 64'(c_w[1]), 64'd4);
      check("chain_row1", 64'(c_w[2]), 64'd3);
      check("chain_row2", 64'(c_w[3]), 64'd2);
      check("chain_row3", 64'(c_w[4]), 64'd1);
      // One swap pulse hops one row per cycle
      c_ws_in = 1; tick();
      c_ws_in = 0;
      for (int t = 0; t < 4; t++) begin
         for (int r = 0; r < 4; r++)
            check($sformatf("chain_swap_t%0d_r%0d", t, r), 64'(c_s[r+1]), 64'(r == t));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global timeout so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
